// File: rtl/hart_control.sv
// Multicycle sequencer for the single-issue hart: steps FETCH/DECODE/EXEC/MEM/WB
// and drives every datapath select/enable from the state plus the decoded opcode.
module hart_control #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       regw,
  output logic       rwsel,
  output logic       asel,
  output logic       bsel,
  output logic [3:0] aluctl,
  output logic       retire,
  output logic [1:0] fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_BUS     = 2'b10;

  localparam logic [TIMEOUT_W-1:0] LP_TMO = TIMEOUT_W'(TIMEOUT);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_fault;
  logic [1:0]           w_fault_next;
  logic [TIMEOUT_W-1:0] r_tcnt;

  logic w_is_alu, w_is_aluimm, w_is_lui, w_is_load, w_is_store, w_legal;
  logic w_ready, w_tmo, w_alu_on;

  assign w_is_alu    = (opcode == OP_ALU);
  assign w_is_aluimm = (opcode == OP_ALUIMM);
  assign w_is_lui    = (opcode == OP_LUI);
  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_legal     = w_is_alu | w_is_aluimm | w_is_lui | w_is_load | w_is_store;

  // Qualifying ready with reset keeps IR/PC writes off while reset is held low.
  assign w_ready = mem_ready & reset;
  assign w_tmo   = (TIMEOUT != 0) && (r_tcnt == LP_TMO) && !w_ready;

  assign state = r_state;
  assign fault = r_fault;

  // ALU controls persist through MEM and WB so the address/result stay stable.
  assign w_alu_on = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

  always_comb begin
    asel   = 1'b0;
    bsel   = 1'b0;
    aluctl = '0;
    if (w_alu_on) begin
      asel = w_is_lui;
      bsel = ~w_is_alu;
      if (w_is_alu)
        aluctl = {funct7_5, funct3};
      else if (w_is_aluimm)
        aluctl = {(funct3 == 3'b101) & funct7_5, funct3};
    end
  end

  always_comb begin
    w_next       = r_state;
    w_fault_next = r_fault;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    regw         = 1'b0;
    rwsel        = 1'b0;
    retire       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (w_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_tmo) begin
          w_next       = S_TRAP;
          w_fault_next = F_BUS;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next       = S_TRAP;
          w_fault_next = F_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else begin
          regw   = 1'b1;
          retire = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = w_is_store;
        if (w_ready) begin
          if (w_is_store) begin
            retire = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_tmo) begin
          w_next       = S_TRAP;
          w_fault_next = F_BUS;
        end
      end
      S_WB: begin
        regw   = 1'b1;
        rwsel  = 1'b1;
        retire = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_fault <= F_NONE;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault_next;
      // Clearing on every state change covers entry to both FETCH and MEM.
      if (w_next != r_state)
        r_tcnt <= '0;
      else if (mem_req && !mem_ready && (r_tcnt != '1))
        r_tcnt <= r_tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hart_control.sv
// Directed bench for hart_control: per-scenario tasks with hand-computed expectations.
module tb_hart_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       mem_ready;

  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, regw, rwsel, asel, bsel, retire;
  logic [3:0] aluctl;
  logic [1:0] fault;
  logic [2:0] state;

  logic       z_mem_req, z_mem_we, z_addr_sel, z_ir_we, z_pc_we, z_regw, z_rwsel, z_asel, z_bsel, z_retire;
  logic [3:0] z_aluctl;
  logic [1:0] z_fault;
  logic [2:0] z_state;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  always #5 clk = ~clk;

  hart_control #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .regw(regw), .rwsel(rwsel), .asel(asel), .bsel(bsel),
    .aluctl(aluctl), .retire(retire), .fault(fault), .state(state)
  );

  // Same stimulus, timeout check disabled.
  hart_control #(.TIMEOUT(0), .TIMEOUT_W(8)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .mem_ready(mem_ready), .mem_req(z_mem_req), .mem_we(z_mem_we), .addr_sel(z_addr_sel),
    .ir_we(z_ir_we), .pc_we(z_pc_we), .regw(z_regw), .rwsel(z_rwsel), .asel(z_asel), .bsel(z_bsel),
    .aluctl(z_aluctl), .retire(z_retire), .fault(z_fault), .state(z_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_ALU;
    funct3    = 3'b000;
    funct7_5  = 1'b0;
    #2;
    total++;
    if (state !== 3'd0 || mem_req !== 1'b1 || fault !== 2'b00 || addr_sel !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got state=%0d mem_req=%b fault=%b addr_sel=%b want 0 1 00 0",
               state, mem_req, fault, addr_sel);
    end
    total++;
    if ({ir_we, pc_we, regw, retire, mem_we} !== 5'b0) begin
      bad++;
      $display("FAIL reset_enables: got ir/pc/regw/retire/mem_we=%b want 00000",
               {ir_we, pc_we, regw, retire, mem_we});
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_alu_stream();
    apply_reset();
    opcode = OP_ALU; funct3 = 3'b000; funct7_5 = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [2:0] ph;
      ph = 3'(i % 3);
      #1;
      total++;
      if (state !== ph) begin
        bad++;
        $display("FAIL alu_state[%0d]: got %0d want %0d", i, state, ph);
      end
      total++;
      if (retire !== (ph == 3'd2) || regw !== (ph == 3'd2) || ir_we !== (ph == 3'd0)) begin
        bad++;
        $display("FAIL alu_enables[%0d]: got retire=%b regw=%b ir_we=%b for state %0d",
                 i, retire, regw, ir_we, ph);
      end
      if (ph == 3'd2) begin
        total++;
        if (aluctl !== 4'b1000 || bsel !== 1'b0 || asel !== 1'b0 || rwsel !== 1'b0) begin
          bad++;
          $display("FAIL alu_ctl[%0d]: got aluctl=%b asel=%b bsel=%b rwsel=%b want 1000 0 0 0",
                   i, aluctl, asel, bsel, rwsel);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_wait();
    logic [2:0] st  [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic       rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    opcode = OP_LOAD; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      total++;
      if (state !== st[i] || retire !== (i == 8)) begin
        bad++;
        $display("FAIL load_seq[%0d]: got state=%0d retire=%b want %0d %b", i, state, retire, st[i], (i == 8));
      end
      if (st[i] == 3'd3) begin
        total++;
        if (mem_req !== 1'b1 || addr_sel !== 1'b1 || mem_we !== 1'b0 || bsel !== 1'b1 || aluctl !== 4'b0000) begin
          bad++;
          $display("FAIL load_mem[%0d]: got req=%b addr_sel=%b we=%b bsel=%b aluctl=%b want 1 1 0 1 0000",
                   i, mem_req, addr_sel, mem_we, bsel, aluctl);
        end
      end
      total++;
      if (regw !== (st[i] == 3'd4) || rwsel !== (st[i] == 3'd4)) begin
        bad++;
        $display("FAIL load_wb[%0d]: got regw=%b rwsel=%b in state %0d", i, regw, rwsel, st[i]);
      end
      tick();
    end
  endtask

  task automatic test_store_aluimm();
    logic [6:0] op  [16] = '{OP_STORE, OP_STORE, OP_STORE, OP_STORE,
                             OP_ALUIMM, OP_ALUIMM, OP_ALUIMM, OP_ALUIMM, OP_ALUIMM, OP_ALUIMM,
                             OP_ALUIMM, OP_ALUIMM, OP_ALUIMM, OP_LUI, OP_LUI, OP_LUI};
    logic [2:0] f3  [16] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001,
                             3'b101, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010};
    logic [2:0] st  [16] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd0,
                             3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    logic [3:0] ctl [16] = '{4'b0, 4'b0, 4'b0000, 4'b0000, 4'b0, 4'b0, 4'b0001, 4'b0,
                             4'b0, 4'b1101, 4'b0, 4'b0, 4'b0000, 4'b0, 4'b0, 4'b0000};
    apply_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic ret_e, regw_e, alu_e;
      opcode   = op[i];
      funct3   = f3[i];
      funct7_5 = (i >= 4);
      ret_e    = (i == 3) || (i == 6) || (i == 9) || (i == 12) || (i == 15);
      regw_e   = ret_e && (i != 3);
      alu_e    = (st[i] == 3'd2) || (st[i] == 3'd3);
      #1;
      total++;
      if (state !== st[i] || retire !== ret_e || regw !== regw_e || mem_we !== (i == 3)) begin
        bad++;
        $display("FAIL st_imm_seq[%0d]: got state=%0d retire=%b regw=%b mem_we=%b want %0d %b %b %b",
                 i, state, retire, regw, mem_we, st[i], ret_e, regw_e, (i == 3));
      end
      if (alu_e) begin
        total++;
        if (aluctl !== ctl[i] || bsel !== 1'b1 || asel !== (i == 15)) begin
          bad++;
          $display("FAIL st_imm_ctl[%0d]: got aluctl=%b asel=%b bsel=%b want %b %b 1",
                   i, aluctl, asel, bsel, ctl[i], (i == 15));
        end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    opcode = 7'b1111111; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
    tick();
    #1;
    total++;
    if (state !== 3'd1 || fault !== 2'b00) begin
      bad++;
      $display("FAIL illegal_decode: got state=%0d fault=%b want 1 00", state, fault);
    end
    tick();
    for (int i = 0; i < 21; i++) begin
      mem_ready = i[0];
      #1;
      total++;
      if (state !== 3'd7 || fault !== 2'b01 || mem_req !== 1'b0 || {ir_we, pc_we, regw, retire} !== 4'b0) begin
        bad++;
        $display("FAIL illegal_trap[%0d]: got state=%0d fault=%b mem_req=%b en=%b want 7 01 0 0000",
                 i, state, fault, mem_req, {ir_we, pc_we, regw, retire});
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    opcode = OP_ALU; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (state !== 3'd0 || fault !== 2'b00) begin
        bad++;
        $display("FAIL tmo_wait[%0d]: got state=%0d fault=%b want 0 00", i, state, fault);
      end
      tick();
    end
    total++;
    if (state !== 3'd7 || fault !== 2'b10 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL tmo_fetch_trap: got state=%0d fault=%b mem_req=%b want 7 10 0", state, fault, mem_req);
    end
    for (int i = 0; i < 300; i++) tick();
    total++;
    if (z_state !== 3'd0 || z_fault !== 2'b00 || z_mem_req !== 1'b1) begin
      bad++;
      $display("FAIL tmo_disabled: got state=%0d fault=%b mem_req=%b want 0 00 1", z_state, z_fault, z_mem_req);
    end

    // Ready arriving on the cycle the count reaches TIMEOUT completes the fetch.
    apply_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b1;
    #1;
    total++;
    if (state !== 3'd0 || ir_we !== 1'b1 || pc_we !== 1'b1) begin
      bad++;
      $display("FAIL tmo_edge_fetch: got state=%0d ir_we=%b pc_we=%b want 0 1 1", state, ir_we, pc_we);
    end
    tick();
    total++;
    if (state !== 3'd1 || fault !== 2'b00) begin
      bad++;
      $display("FAIL tmo_edge_decode: got state=%0d fault=%b want 1 00", state, fault);
    end

    // Counter from a slow fetch must not carry into MEM.
    apply_reset();
    opcode = OP_LOAD; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (state !== 3'd3 || fault !== 2'b00) begin
        bad++;
        $display("FAIL tmo_mem_wait[%0d]: got state=%0d fault=%b want 3 00", i, state, fault);
      end
      tick();
    end
    total++;
    if (state !== 3'd7 || fault !== 2'b10) begin
      bad++;
      $display("FAIL tmo_mem_trap: got state=%0d fault=%b want 7 10", state, fault);
    end
  endtask

  task automatic test_reset_mid_mem();
    apply_reset();
    opcode = OP_LOAD; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    #1;
    total++;
    if (state !== 3'd3 || mem_req !== 1'b1 || addr_sel !== 1'b1) begin
      bad++;
      $display("FAIL mid_mem_setup: got state=%0d mem_req=%b addr_sel=%b want 3 1 1", state, mem_req, addr_sel);
    end
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    total++;
    if (state !== 3'd0 || mem_req !== 1'b1 || addr_sel !== 1'b0 || regw !== 1'b0 || fault !== 2'b00 ||
        ir_we !== 1'b0 || pc_we !== 1'b0) begin
      bad++;
      $display("FAIL mid_mem_reset: got state=%0d req=%b addr_sel=%b regw=%b fault=%b ir_we=%b pc_we=%b want 0 1 0 0 00 0 0",
               state, mem_req, addr_sel, regw, fault, ir_we, pc_we);
    end
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (state !== 3'd0 || ir_we !== 1'b1 || pc_we !== 1'b1) begin
      bad++;
      $display("FAIL resume_fetch: got state=%0d ir_we=%b pc_we=%b want 0 1 1", state, ir_we, pc_we);
    end
    tick();
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL resume_decode: got state=%0d want 1", state);
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_load_wait();
    test_store_aluimm();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/hart_control.md
Name: hart_control

Overview:
Multicycle sequencer for the single-issue hart datapath: regfile, ALU, decoder, and one shared memory port used for both instruction fetch and load/store.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives all datapath selects and enables (regfile write, ALU operand and op, memory request, IR/PC load) from a state register plus the decoded opcode.
- Traps on illegal opcodes and on memory that never answers.

Parameters:
TIMEOUT, 255, max cycles a mem_req may stay unanswered before bus-timeout trap; 0 disables the check
TIMEOUT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TIMEOUT_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
opcode  in  7  opcode field of IR (decoder output)
funct3  in  3  funct3 field of IR
funct7_5  in  1  bit 30 of IR
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  request is a store
addr_sel  out  1  memaddr source: 0=PC, 1=ALU result
ir_we  out  1  load IR from memdata
pc_we  out  1  PC <= PC+4
regw  out  1  regfile write enable
rwsel  out  1  regfile write data: 0=ALU, 1=memdata
asel  out  1  ALU A: 0=r1, 1=zero
bsel  out  1  ALU B: 0=r2, 1=imm
aluctl  out  4  ALU operation
retire  out  1  one-cycle pulse when an instruction completes
fault  out  2  00 none, 01 illegal opcode, 10 bus timeout
state  out  3  current state (debug)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While reset is low, immediately: state=FETCH, fault=00, timeout count=0. All outputs are then FETCH-state values: mem_req=1, all other enables 0.
- Reset asserted mid-access abandons the access with no write to regfile, IR or PC.
- All outputs are combinational from state, opcode, funct3, funct7_5 and mem_ready. Opcode is stable from DECODE onward because the IR loads only in FETCH.
- Encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Supported opcodes:
  - ALUIMM 0010011
  - ALU 0110011
  - LOAD 0000011
  - STORE 0100011
  - LUI 0110111
- FETCH:
  - Outputs: mem_req=1, addr_sel=0, mem_we=0.
  - If mem_ready: ir_we=1, pc_we=1, next state DECODE. Otherwise stay.
- DECODE:
  - One cycle for regfile read; all enables 0.
  - Supported opcode goes to EXEC.
  - Any other opcode goes to TRAP with fault=01.
- EXEC:
  - ALU: bsel=0, asel=0, aluctl={funct7_5,funct3}, regw=1, rwsel=0, retire=1, next FETCH.
  - ALUIMM: bsel=1, asel=0. aluctl={funct3==101 ? funct7_5 : 0, funct3}. regw=1, retire=1, next FETCH.
  - LUI: asel=1, bsel=1, aluctl=0000, regw=1, rwsel=0, retire=1, next FETCH.
  - LOAD/STORE: asel=0, bsel=1, aluctl=0000, no writes, next MEM.
- MEM:
  - Outputs: mem_req=1, addr_sel=1, mem_we=(STORE); ALU held as in EXEC.
  - On mem_ready: STORE asserts retire and goes to FETCH; LOAD goes to WB.
- WB: regw=1, rwsel=1, ALU held, retire=1, next FETCH.
- TRAP: all enables and mem_req 0. Stays until reset; fault holds its code.
- Timeout counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle mem_req=1 and mem_ready=0; saturates at all-ones.
  - When TIMEOUT!=0 and count==TIMEOUT with mem_ready still 0: next state TRAP, fault=10.
  - mem_ready in the same cycle as count==TIMEOUT wins; the access completes normally.
- mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory:
  - ALU/ALUIMM/LUI: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle adds one.
- Back-to-back instructions: FETCH follows the retire cycle directly, with no bubble.

Test Plan:
- ALU stream, zero-wait: mem_ready=1, opcode=0110011, funct3=000, funct7_5=1 -> states 0,1,2 repeating; aluctl=1000 in EXEC; retire every 3rd cycle; regw only in EXEC.
- LOAD with 2 wait cycles per access: opcode=0000011, mem_ready low 2 cycles in FETCH and in MEM -> retire in cycle 9. In MEM: addr_sel=1, mem_we=0. WB asserts regw=1, rwsel=1.
- STORE then ALUIMM: STORE shows mem_we=1 only in MEM and retire at cycle 4 with regw never 1. Following ALUIMM with funct3=001, funct7_5=1 -> aluctl=0001.
- Illegal opcode 1111111 after fetch -> TRAP at cycle 3, fault=01; mem_req stays 0 for 20 further cycles.
- Timeout, TIMEOUT=4: mem_ready held 0 in FETCH -> TRAP after 5 cycles, fault=10. Repeat with mem_ready=1 on the 5th cycle -> DECODE, fault=00.
- Reset low mid-MEM with mem_req=1 -> same cycle: state=0, mem_req=1, addr_sel=0, regw=0, fault=00. Normal fetch resumes after reset rises.
